hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 tb/tb_hazard_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Brief    : Pipeline hazard unit: operand forwarding, load-use stall,
//             branch flush, data-memory wait/timeout FSM and stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [15:0] StallCnt
);

    // WaitCnt only has to reach TIMEOUT-1 before the FSM leaves WAIT.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  wait_cnt_q;
    logic [15:0]    stall_cnt_q;
    logic [15:0]    stall_cnt_d;
    logic           lw_stall;
    logic           mem_stall;
    logic           in_error;

    // Operand forwarding: the younger result in Memory wins over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign in_error  = (state_q == ST_ERROR);
    assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    // A ready in the same cycle as the request releases the stall at once.
    assign mem_stall = !in_error && MemReqM && !MemReadyM;

    // Stall/flush arbitration: error freezes, memory wait dominates, then branch over load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (in_error) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (mem_stall) begin
            // Execute is held, so a pending branch flushes once the wait ends.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall && !PCSrcE;
            StallD = lw_stall && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // Memory wait FSM with timeout counter; ERROR is left only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    if (MemReqM && !MemReadyM)
                        state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (MemReadyM) begin
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= ST_ERROR;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_ERROR: begin
                    wait_cnt_q <= '0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign MemErr = in_error;

    // Saturating count of cycles lost to any stall outside the error state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!in_error && (mem_stall || lw_stall) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_controller
//  Brief    : Directed table-driven bench for hazard_controller (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW, MemErr;
    logic [15:0] StallCnt;

    int tests = 0;
    int fails = 0;

    hazard_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pcs;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stall/flush bundle {F,D,E,M,fD,fE,fW}
    task automatic chk_sf(input string name, input logic [6:0] exp);
        chk(name, {9'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {9'd0, exp});
    endtask

    task automatic clear_inputs;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    vec_t vt[12];

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        //        rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc  pcs  fa     fb     sf sd fd fe
        vt[0]  = '{0,  0,   5,   0,   0,  5,  5,  1,  1,  2'b00,0,  2'b10, 2'b00, 0, 0, 0, 0};
        vt[1]  = '{0,  0,   5,   0,   0,  5,  5,  0,  1,  2'b00,0,  2'b01, 2'b00, 0, 0, 0, 0};
        vt[2]  = '{0,  0,   0,   0,   0,  0,  0,  1,  1,  2'b00,0,  2'b00, 2'b00, 0, 0, 0, 0};
        vt[3]  = '{0,  0,   1,   7,   0,  0,  7,  1,  1,  2'b00,0,  2'b00, 2'b01, 0, 0, 0, 0};
        vt[4]  = '{0,  0,   9,   9,   0,  9,  9,  1,  1,  2'b00,0,  2'b10, 2'b10, 0, 0, 0, 0};
        vt[5]  = '{0,  0,   4,   4,   0,  4,  6,  0,  0,  2'b00,0,  2'b00, 2'b00, 0, 0, 0, 0};
        vt[6]  = '{0,  3,   0,   0,   3,  0,  0,  0,  0,  2'b01,0,  2'b00, 2'b00, 1, 1, 0, 1};
        vt[7]  = '{0,  3,   0,   0,   3,  0,  0,  0,  0,  2'b01,1,  2'b00, 2'b00, 0, 0, 1, 1};
        vt[8]  = '{0,  0,   0,   0,   0,  0,  0,  0,  0,  2'b01,0,  2'b00, 2'b00, 0, 0, 0, 0};
        vt[9]  = '{3,  0,   0,   0,   3,  0,  0,  0,  0,  2'b10,0,  2'b00, 2'b00, 0, 0, 0, 0};
        vt[10] = '{0,  0,   0,   0,   0,  0,  0,  0,  0,  2'b00,1,  2'b00, 2'b00, 0, 0, 1, 1};
        vt[11] = '{8,  2,   0,   0,   8,  0,  0,  0,  0,  2'b01,0,  2'b00, 2'b00, 1, 1, 0, 1};

        // Reset state, asserted with no clock edge yet
        #1;
        chk("reset_StallCnt", StallCnt, 16'd0);
        chk("reset_MemErr", {15'd0, MemErr}, 16'd0);
        chk_sf("reset_stalls", 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
            RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
            RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
            ResultSrcE = vt[i].rsrc; PCSrcE = vt[i].pcs;
            #1;
            chk($sformatf("vec%0d_ForwardAE", i), {14'd0, ForwardAE}, {14'd0, vt[i].fa});
            chk($sformatf("vec%0d_ForwardBE", i), {14'd0, ForwardBE}, {14'd0, vt[i].fb});
            chk_sf($sformatf("vec%0d_stallflush", i),
                   {vt[i].sf, vt[i].sd, 1'b0, 1'b0, vt[i].fd, vt[i].fe, 1'b0});
        end

        // Load-use stall counted on the next edge
        clear_inputs();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3;
        @(negedge clk); #1;
        chk("lw_StallCnt", StallCnt, 16'd1);
        clear_inputs();

        // Memory wait of 3 cycles, branch held in Execute during the wait
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_sf($sformatf("memwait%0d_stalls", c), 7'b1111001);
            @(negedge clk);
        end
        MemReadyM = 1'b1;
        #1;
        chk_sf("memready_release", 7'b0000110);
        @(negedge clk); #1;
        chk("memwait_StallCnt", StallCnt, 16'd3);
        chk("memwait_MemErr", {15'd0, MemErr}, 16'd0);
        clear_inputs();

        // Timeout with TIMEOUT=4: error after 5 edges; also proves FSM was back in IDLE
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk); #1;
            chk($sformatf("timeout_edge%0d_MemErr", e), {15'd0, MemErr}, (e == 5) ? 16'd1 : 16'd0);
        end
        chk("timeout_StallCnt", StallCnt, 16'd5);
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3; MemReadyM = 1'b1;
        #1;
        chk_sf("error_frozen", 7'b1111000);
        @(negedge clk); #1;
        chk("error_sticky", {15'd0, MemErr}, 16'd1);
        chk("error_cnt_frozen", StallCnt, 16'd5);
        // Asynchronous reset pulse between edges
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_MemErr", {15'd0, MemErr}, 16'd0);
        chk("async_rst_StallCnt", StallCnt, 16'd0);
        rst_n = 1'b1;
        // Back in IDLE: a request that is ready at once causes no stall or wait
        @(negedge clk);
        MemReqM = 1'b1; MemReadyM = 1'b1;
        #1;
        chk_sf("post_rst_idle", 7'b0000000);
        @(negedge clk); #1;
        chk("post_rst_cnt", StallCnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
